// File: rtl/matcalc_pkg.sv
// ============================================================================
// matcalc_pkg -- shared types and widths for the result serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package matcalc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int RESULT_WIDTH = 160;
    localparam int BYTE_WIDTH   = 8;

endpackage

`default_nettype wire

// File: rtl/ser_beat_counter.sv
// ============================================================================
// ser_beat_counter -- beat index within a frame, with clear and enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_beat_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/result_serializer.sv
// ============================================================================
// result_serializer -- parallel frame to MSB-first beat stream, valid/ready.
// Optional out_parity port enabled by macro RESULT_SERIALIZER_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_serializer
    import matcalc_pkg::*;
#(
    parameter int IN_WIDTH  = RESULT_WIDTH,
    parameter int OUT_WIDTH = BYTE_WIDTH
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [IN_WIDTH-1:0]  load_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
`ifdef RESULT_SERIALIZER_PARITY_EN
    output logic                 out_parity,
`endif
    output logic                 busy
);

    localparam int BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || BEATS < 2) begin : g_bad_cfg
        $error("result_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end

    ser_state_t            state;
    ser_state_t            state_next;
    logic [IN_WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  accept;
    logic                  xfer;
    logic                  at_last;

    assign at_last = (beat_cnt == LAST_BEAT);
    assign accept  = load_valid && load_ready;
    assign xfer    = out_valid && out_ready;

    ser_beat_counter #(
        .WIDTH (CNT_W)
    ) u_beat_counter (
        .clock  (clock),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (xfer && !at_last),
        .count  (beat_cnt)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                shift_reg <= load_data;
            end else if (xfer) begin
                shift_reg <= {shift_reg[IN_WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
            end
        end
    end

    // Outputs decode from state only, so reset clears them without a clock edge.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = shift_reg[IN_WIDTH-1 -: OUT_WIDTH];
                out_last  = at_last;
                if (out_ready && at_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef RESULT_SERIALIZER_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_serializer.sv
// ============================================================================
// tb_result_serializer -- directed self-checking bench for result_serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_serializer;

    logic         clock;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [159:0] load_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
`ifdef RESULT_SERIALIZER_PARITY_EN
    logic         out_parity;
`endif

    logic         w_load_valid;
    logic         w_load_ready;
    logic [95:0]  w_load_data;
    logic         w_out_valid;
    logic         w_out_ready;
    logic [11:0]  w_out_data;
    logic         w_out_last;
    logic         w_busy;
`ifdef RESULT_SERIALIZER_PARITY_EN
    logic         w_out_parity;
`endif

    int checks = 0;
    int errors = 0;

    result_serializer u_dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
`ifdef RESULT_SERIALIZER_PARITY_EN
        .out_parity (out_parity),
`endif
        .busy       (busy)
    );

    result_serializer #(
        .IN_WIDTH  (96),
        .OUT_WIDTH (12)
    ) u_dut_wide (
        .clock      (clock),
        .rst_n      (rst_n),
        .load_valid (w_load_valid),
        .load_ready (w_load_ready),
        .load_data  (w_load_data),
        .out_valid  (w_out_valid),
        .out_ready  (w_out_ready),
        .out_data   (w_out_data),
        .out_last   (w_out_last),
`ifdef RESULT_SERIALIZER_PARITY_EN
        .out_parity (w_out_parity),
`endif
        .busy       (w_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load(input logic [159:0] frame);
        load_valid = 1'b1;
        load_data  = frame;
        check("load_ready_idle", load_ready, 1);
        @(negedge clock);
        load_valid = 1'b0;
        check("busy_send", busy, 1);
    endtask

    // Walks all 20 beats of a frame; stall applies out_ready pattern 1,0,0,1,...
    task automatic run_beats(input logic [159:0] frame, input bit stall);
        int   b   = 0;
        int   cyc = 0;
        logic rdy;
        logic [7:0] exp;
        while (b < 20 && cyc < 200) begin
            exp = frame[159-8*b -: 8];
            check("out_valid", out_valid, 1);
            check("load_ready_send", load_ready, 0);
            check("out_data", out_data, exp);
            check("out_last", out_last, (b == 19));
`ifdef RESULT_SERIALIZER_PARITY_EN
            check("out_parity", out_parity, ^exp);
`endif
            rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            out_ready = rdy;
            if (rdy) b++;
            cyc++;
            @(negedge clock);
        end
        out_ready = 1'b0;
        check("beats_done", b, 20);
        check("idle_out_valid", out_valid, 0);
        check("idle_out_data", out_data, 0);
        check("idle_load_ready", load_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    logic [159:0] frame_f;
    logic [159:0] frame_g;
    logic [159:0] frame_a;
    logic [11:0]  wide_exp [8];

    initial begin
        frame_f = 160'h0102030405060708090A0B0C0D0E0F1011121314;
        frame_g = {20{8'h55}};
        frame_a = {20{8'hAA}};
        wide_exp = '{12'hABC, 12'h123, 12'h456, 12'h789, 12'hDEF, 12'h012, 12'h345, 12'h678};

        rst_n        = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        out_ready    = 1'b0;
        w_load_valid = 1'b0;
        w_load_data  = '0;
        w_out_ready  = 1'b0;

        #3;
        check("rst_load_ready", load_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        // Back-to-back beats with consumer always ready
        load(frame_f);
        run_beats(frame_f, 1'b0);

        // Stalled consumer
        @(negedge clock);
        load(frame_f);
        run_beats(frame_f, 1'b1);

        // Second frame offered during SEND must wait for IDLE
        @(negedge clock);
        load(frame_f);
        load_valid = 1'b1;
        load_data  = frame_g;
        run_beats(frame_f, 1'b0);
        @(negedge clock);
        load_valid = 1'b0;
        check("second_frame_busy", busy, 1);
        check("second_frame_beat0", out_data, 8'h55);
        run_beats(frame_g, 1'b0);

        // Reset in the middle of a frame
        @(negedge clock);
        load(frame_f);
        out_ready = 1'b1;
        repeat (5) @(negedge clock);
        out_ready = 1'b0;
        check("pre_reset_beat5", out_data, 8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_load_ready", load_ready, 1);
        @(negedge clock);
        check("held_rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clock);
        check("post_rst_out_valid", out_valid, 0);
        load(frame_a);
        check("post_rst_beat0", out_data, 8'hAA);
        run_beats(frame_a, 1'b0);

        // 96-bit frame in 12-bit beats
        @(negedge clock);
        w_load_valid = 1'b1;
        w_load_data  = 96'hABC123456789DEF012345678;
        check("wide_load_ready", w_load_ready, 1);
        @(negedge clock);
        w_load_valid = 1'b0;
        w_out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("wide_out_valid", w_out_valid, 1);
            check("wide_out_data", w_out_data, wide_exp[i]);
            check("wide_out_last", w_out_last, (i == 7));
            @(negedge clock);
        end
        w_out_ready = 1'b0;
        check("wide_idle_valid", w_out_valid, 0);
        check("wide_idle_ready", w_load_ready, 1);
        check("wide_idle_busy", w_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 Parameter IN_WIDTH, default 160, is the width of the parallel result word accepted per frame.
REQ-002 Parameter OUT_WIDTH, default 8, is the width of each serial output beat.
REQ-003 Port clock, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset: asynchronous assert, active-low.
REQ-005 Port load_valid, input, 1, means the producer presents a frame on load_data.
REQ-006 Port load_ready, output, 1, means the block can accept a frame this cycle.
REQ-007 Port load_data, input, IN_WIDTH, is the parallel frame, most-significant chunk first on the wire.
REQ-008 Port out_valid, output, 1, means out_data holds a valid beat.
REQ-009 Port out_ready, input, 1, means the consumer takes the beat this cycle.
REQ-010 Port out_data, output, OUT_WIDTH, is the current beat.
REQ-011 Port out_last, output, 1, marks the final beat of a frame, qualified by out_valid.
REQ-012 Port busy, output, 1, is high whenever a frame is held (state SEND).

Function
REQ-013 The block SHALL have two states: IDLE and SEND.
REQ-014 In IDLE, load_ready=1, out_valid=0, and busy=0.
REQ-015 IDLE->SEND on load_valid&&load_ready: latch load_data into the shift register and clear the beat counter to 0.
REQ-016 Latency: a frame accepted on edge N SHALL present beat 0 (load_data[IN_WIDTH-1 -: OUT_WIDTH]) with out_valid=1 after edge N.
REQ-017 In SEND, out_valid=1, load_ready=0, and load_valid is ignored; no frame is overwritten.
REQ-018 Beat transfer occurs on out_valid&&out_ready: shift the register left by OUT_WIDTH, zero-fill, and increment the counter.
REQ-019 While out_valid&&!out_ready, out_data, out_last, and the counter SHALL hold stable (no beat loss or duplication).
REQ-020 The frame SHALL have BEATS=IN_WIDTH/OUT_WIDTH beats; out_last=1 only when counter==BEATS-1.
REQ-021 A transfer with out_last=1 SHALL cause SEND->IDLE; load_ready returns next cycle, so at least one idle cycle separates frames.
REQ-022 out_data SHALL be 0 whenever out_valid=0.
REQ-023 The counter SHALL be $clog2(BEATS) bits and SHALL never wrap inside a frame.
REQ-024 Elaboration SHALL fail unless IN_WIDTH%OUT_WIDTH==0 and BEATS>=2.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, counter 0, shift register 0, out_valid=0, out_last=0, out_data=0, busy=0, load_ready=1.
REQ-026 Reset during SEND SHALL abort the frame with no further beats; the first load after reset release starts a fresh frame at beat 0.

Configuration
REQ-027 With macro RESULT_SERIALIZER_PARITY_EN defined, output out_parity (1 bit) SHALL exist, equal to even parity (XOR) of out_data, and be 0 when out_valid=0 or in reset.
REQ-028 Without RESULT_SERIALIZER_PARITY_EN, port out_parity and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package matcalc_pkg SHALL hold the state enum ser_state_t {IDLE, SEND} and constants RESULT_WIDTH=160 and BYTE_WIDTH=8.
REQ-030 The beat counter SHALL be a sub-module ser_beat_counter (async active-low reset, clear, enable, count output); shift and FSM logic stay in result_serializer.

Verification
REQ-031 Defaults; load_data=160'h0102...14 (bytes 01..14 hex); out_ready held 1 -> 20 consecutive beats 01,02,...,14; out_last only on 14; load_ready=1 the cycle after.
REQ-032 Same frame; out_ready toggled 1,0,0,1,... -> each stalled beat holds value; sequence still 01..14; exactly 20 transfers.
REQ-033 Assert load_valid with a second frame during SEND -> second frame not accepted and current beats unchanged; second frame accepted only after return to IDLE.
REQ-034 rst_n pulsed low after beat 5 -> out_valid/out_data drop to 0 without waiting for a clock edge; next frame AA..AA begins at beat 0 with value AA.
REQ-035 Macro RESULT_SERIALIZER_PARITY_EN defined, beats 07 and 03 -> out_parity 1 then 0; build without the macro compiles with no out_parity port.
REQ-036 IN_WIDTH=96, OUT_WIDTH=12, frame 96'hABC_... -> 8 beats, first ABC, out_last on beat 7.
